snn_osc_network: RTL and testbench
==================================

Name: snn_osc_network

Overview:
- Parametrised successor to the fixed two-neuron, two-synapse oscillator top.
- Contains N leaky integrate-and-fire (LIF) neurons, all-to-all signed synaptic weights, and per-neuron bias currents.
- Weights and biases are runtime-configurable through a write port that is only accepted while the network is halted.
- Sits beneath the TinyTapeout wrapper; the wrapper maps `spike_any`/`spike` to `uo_out` and the config port to `ui_in`/`uio_in`.

Parameters:
- N_NEURONS, 2: neuron count (2..8).
- V_WIDTH, 8: membrane potential width, unsigned.
- W_WIDTH, 4: synaptic weight width, signed two's complement.
- W_SCALE, 4: left shift applied to weight contributions.
- THRESHOLD, 200: fire when the next potential is >= THRESHOLD; must be <= 2^V_WIDTH-1.
- LEAK_SHIFT, 3: leak = v >> LEAK_SHIFT.
- REFRACT_CYCLES, 4: enabled edges a neuron is held silent after firing.
- ADDR_WIDTH, 4: config address width; must hold N*N+N entries.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- run  in  1  1 = network advances every edge; 0 = frozen
- cfg_valid  in  1  config write request
- cfg_ready  out  1  = !run (combinational)
- cfg_addr  in  ADDR_WIDTH  0..N*N-1 selects weight[i][j] (i = addr/N target, j = addr%N source); N*N..N*N+N-1 selects bias[addr-N*N]
- cfg_wdata  in  V_WIDTH  weight uses low W_WIDTH bits (signed); bias uses all bits (unsigned)
- spike  out  N_NEURONS  registered one-cycle spike pulses
- spike_any  out  1  registered OR of the next spike vector (same cycle as `spike`)
- spike_count  out  16  total spikes (see Optional Feature)

Behaviour:
- Reset: v, refr_cnt, spike, spike_any, weights, biases and spike_count all go to 0. Reset overrides run and cfg in the same cycle.
- Config:
  - A write occurs on an edge where cfg_valid && cfg_ready.
  - Addresses >= N*N+N are ignored.
  - Writes with run=1 are dropped; there is no queuing.
- run=0: v, refr_cnt and spike_count hold; spike and spike_any are forced to 0 on the next edge.
- Per neuron i on each edge with run=1:
  - If refr_cnt != 0: refr_cnt -= 1, v = 0, spike_i = 0.
  - Otherwise: syn = sum over j of (weight[i][j] << W_SCALE) for each j with spike_j (the registered previous vector) = 1. Self-weights weight[i][i] are included.
  - Compute s = v - (v >> LEAK_SHIFT) + bias_i + syn. Use a signed intermediate of V_WIDTH+W_WIDTH+W_SCALE+clog2(N)+2 bits.
  - Clamp s to [0, 2^V_WIDTH-1].
  - If clamped s >= THRESHOLD: spike_i = 1, v = 0, refr_cnt = REFRACT_CYCLES.
  - Else: spike_i = 0, v = clamped s.
- Latency: input spike at edge k affects target v at edge k+1.
- Oscillation period with constant bias b and no synapses = (edges to reach THRESHOLD) + REFRACT_CYCLES.
- Simultaneous spikes: all neurons update from the same registered vector; ordering is irrelevant.
- Weight rewrite takes effect on the first enabled edge after the write.
- Reset mid-operation: everything clears in one cycle, and configuration must be reloaded.

Optional Feature:
- SNN_SPIKE_COUNT_EN defined: spike_count += popcount(next spike vector) on each enabled edge, saturating at 16'hFFFF. It holds when run=0 and clears on reset.
- Undefined: spike_count is tied to 0 and no counter logic is instantiated. The port list is unchanged.

Decomposition:
- Package `snn_pkg`:
  - config address-map helper constants (weight base 0, bias base N*N);
  - the clamp function;
  - typedef `weight_t` (signed W_WIDTH);
  - typedef `vmem_t` (V_WIDTH).
- Sub-module `lif_neuron`, instantiated N_NEURONS times via generate.
  - Inputs: run, bias, syn sum.
  - Owns v, refr_cnt and its spike flop.
- The top owns the config register file, the synapse summation and the count logic.

Test Plan (defaults):
- Single neuron oscillation: reset, bias0=50, all weights 0, run=1.
  - v0 over edges 1-5 = 50, 94, 133, 167, 197.
  - spike[0] high on edge 6; spike[0] low for edges 7-10.
  - Pattern repeats with period 10; spike_any mirrors spike[0].
- Inhibition:
  - Setup: bias0=50, bias1=60, weight[0][1]=-8 (addr 1, wdata 8'h08).
  - neuron1 spikes on edge 4.
  - neuron0 v=69 after edge 5; no spike[0] on edge 6.
- Clamp at zero: bias0=0, bias1=50, weight[0][1]=-8.
  - v0 stays 0 after neuron1 spikes; no underflow wrap.
  - spike[0] never asserts.
- Config gating:
  - cfg_valid with run=1 → cfg_ready=0 and the write is dropped; a readback via behaviour is unchanged.
  - Address 6 (≥ N*N+N) is ignored.
- Reset mid-run: assert reset while v0=133 and refr_cnt of the other neuron is nonzero.
  - Next edge: all state 0.
  - With run=1 and no reconfiguration, there are no spikes.
- Spike count (SNN_SPIKE_COUNT_EN): bias0=bias1=50, 100 enabled edges.
  - spike_count = 20.
  - Freezes while run=0; the macro-off build reads 0.

Source files
------------

// File: rtl/snn_pkg.sv
// -----------------------------------------------------------------------------
// snn_pkg
// Shared types, default widths, config address-map helpers and the membrane
// clamp function for the snn_osc_network oscillator.
//   weight_t : signed synaptic weight at the default width
//   vmem_t   : unsigned membrane potential at the default width
// -----------------------------------------------------------------------------
package snn_pkg;

    localparam int SNN_DEF_N_NEURONS = 2;
    localparam int SNN_DEF_V_WIDTH   = 8;
    localparam int SNN_DEF_W_WIDTH   = 4;

    typedef logic signed [SNN_DEF_W_WIDTH-1:0] weight_t;
    typedef logic        [SNN_DEF_V_WIDTH-1:0] vmem_t;

    // Config address map: weights occupy [0, N*N), biases follow at N*N.
    localparam int CFG_WEIGHT_BASE = 0;

    function automatic int cfg_bias_base(input int n);
        return n * n;
    endfunction

    function automatic int cfg_num_entries(input int n);
        return n * n + n;
    endfunction

    // Saturate a signed value into the unsigned range [0, 2^width-1].
    function automatic logic [31:0] clamp_to_width(input logic signed [31:0] s,
                                                   input int                 width);
        logic signed [31:0] hi;
        hi = (32'sd1 <<< width) - 32'sd1;
        if (s < 32'sd0) begin
            return 32'd0;
        end
        if (s > hi) begin
            return hi;
        end
        return s;
    endfunction

endpackage

// File: rtl/snn_osc_network_lif_neuron.sv
// -----------------------------------------------------------------------------
// lif_neuron
// One leaky integrate-and-fire neuron: owns its membrane potential, its
// refractory down-counter and its registered spike flop.
// Ports:
//   clk_i, reset_i   clock, synchronous active-high reset
//   run_i            1 = advance on this edge, 0 = hold state, spike forced low
//   bias_i           unsigned bias current added every enabled edge
//   syn_i            signed synaptic sum from the previous spike vector
//   spike_next_o     spike value that will be registered on the coming edge
//   spike_o          registered spike pulse
// -----------------------------------------------------------------------------
module lif_neuron
    import snn_pkg::*;
#(
    parameter int V_WIDTH        = 8,
    parameter int S_WIDTH        = 19,
    parameter int THRESHOLD      = 200,
    parameter int LEAK_SHIFT     = 3,
    parameter int REFRACT_CYCLES = 4
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      run_i,
    input  logic [V_WIDTH-1:0]        bias_i,
    input  logic signed [S_WIDTH-1:0] syn_i,
    output logic                      spike_next_o,
    output logic                      spike_o
);

    localparam int RW = (REFRACT_CYCLES > 0) ? $clog2(REFRACT_CYCLES + 1) : 1;

    logic [V_WIDTH-1:0]        v_q, v_d;
    logic [RW-1:0]             refr_q, refr_d;
    logic                      spike_q, spike_d;
    logic signed [S_WIDTH-1:0] s_sum;
    logic [31:0]               s_clamp;

    always_comb begin
        v_d     = v_q;
        refr_d  = refr_q;
        spike_d = 1'b0;
        s_sum   = '0;
        s_clamp = '0;
        if (run_i) begin
            if (refr_q != '0) begin
                refr_d = refr_q - RW'(1);
                v_d    = '0;
            end else begin
                // Widen before arithmetic so the negative synaptic sum cannot
                // wrap the unsigned membrane value.
                s_sum = $signed(S_WIDTH'(v_q))
                      - $signed(S_WIDTH'(v_q >> LEAK_SHIFT))
                      + $signed(S_WIDTH'(bias_i))
                      + syn_i;
                s_clamp = clamp_to_width(32'(s_sum), V_WIDTH);
                if (s_clamp >= 32'(THRESHOLD)) begin
                    spike_d = 1'b1;
                    v_d     = '0;
                    refr_d  = RW'(REFRACT_CYCLES);
                end else begin
                    v_d = s_clamp[V_WIDTH-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            v_q     <= '0;
            refr_q  <= '0;
            spike_q <= 1'b0;
        end else begin
            v_q     <= v_d;
            refr_q  <= refr_d;
            spike_q <= spike_d;
        end
    end

    assign spike_next_o = spike_d;
    assign spike_o      = spike_q;

endmodule

// File: rtl/snn_osc_network.sv
// -----------------------------------------------------------------------------
// snn_osc_network
// N leaky integrate-and-fire neurons with all-to-all signed weights and
// per-neuron bias, configured through a write port accepted only while halted.
// Ports:
//   clk, reset      clock, synchronous active-high reset (clears config too)
//   run             1 = network advances every edge, 0 = frozen
//   cfg_valid       config write request, taken when cfg_ready
//   cfg_ready       = !run
//   cfg_addr        0..N*N-1 weight[addr/N][addr%N], N*N..N*N+N-1 bias
//   cfg_wdata       weight: low W_WIDTH bits signed; bias: all bits unsigned
//   spike           registered spike pulses
//   spike_any       registered OR of the spike vector, aligned with spike
//   spike_count     saturating spike total
// Build option: define SNN_SPIKE_COUNT_EN to include the spike counter;
// otherwise spike_count is tied to zero.
// -----------------------------------------------------------------------------
module snn_osc_network
    import snn_pkg::*;
#(
    parameter int N_NEURONS      = SNN_DEF_N_NEURONS,
    parameter int V_WIDTH        = SNN_DEF_V_WIDTH,
    parameter int W_WIDTH        = SNN_DEF_W_WIDTH,
    parameter int W_SCALE        = 4,
    parameter int THRESHOLD      = 200,
    parameter int LEAK_SHIFT     = 3,
    parameter int REFRACT_CYCLES = 4,
    parameter int ADDR_WIDTH     = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [ADDR_WIDTH-1:0] cfg_addr,
    input  logic [V_WIDTH-1:0]    cfg_wdata,
    output logic [N_NEURONS-1:0]  spike,
    output logic                  spike_any,
    output logic [15:0]           spike_count
);

    localparam int S_WIDTH   = V_WIDTH + W_WIDTH + W_SCALE + $clog2(N_NEURONS) + 2;
    localparam int BIAS_BASE = cfg_bias_base(N_NEURONS);

    logic signed [W_WIDTH-1:0] weight_q [N_NEURONS][N_NEURONS];
    logic [V_WIDTH-1:0]        bias_q   [N_NEURONS];
    logic signed [S_WIDTH-1:0] syn_sum  [N_NEURONS];
    logic [N_NEURONS-1:0]      spike_q;
    logic [N_NEURONS-1:0]      spike_next;
    logic                      spike_any_q;
    logic                      cfg_we;

    assign cfg_ready = !run;
    assign cfg_we    = cfg_valid && cfg_ready;

    // Address decode is an exact match per entry, so out-of-range addresses
    // fall through without touching anything.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                bias_q[i] <= '0;
                for (int j = 0; j < N_NEURONS; j++) begin
                    weight_q[i][j] <= '0;
                end
            end
        end else if (cfg_we) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                if (cfg_addr == ADDR_WIDTH'(BIAS_BASE + i)) begin
                    bias_q[i] <= cfg_wdata;
                end
                for (int j = 0; j < N_NEURONS; j++) begin
                    if (cfg_addr == ADDR_WIDTH'(CFG_WEIGHT_BASE + i * N_NEURONS + j)) begin
                        weight_q[i][j] <= cfg_wdata[W_WIDTH-1:0];
                    end
                end
            end
        end
    end

    // Every target reads the same registered vector, so simultaneous spikes
    // need no ordering.
    always_comb begin
        for (int i = 0; i < N_NEURONS; i++) begin
            syn_sum[i] = '0;
            for (int j = 0; j < N_NEURONS; j++) begin
                if (spike_q[j]) begin
                    syn_sum[i] = syn_sum[i] + (S_WIDTH'(weight_q[i][j]) <<< W_SCALE);
                end
            end
        end
    end

    for (genvar gi = 0; gi < N_NEURONS; gi++) begin : g_neuron
        lif_neuron #(
            .V_WIDTH        (V_WIDTH),
            .S_WIDTH        (S_WIDTH),
            .THRESHOLD      (THRESHOLD),
            .LEAK_SHIFT     (LEAK_SHIFT),
            .REFRACT_CYCLES (REFRACT_CYCLES)
        ) u_neuron (
            .clk_i        (clk),
            .reset_i      (reset),
            .run_i        (run),
            .bias_i       (bias_q[gi]),
            .syn_i        (syn_sum[gi]),
            .spike_next_o (spike_next[gi]),
            .spike_o      (spike_q[gi])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            spike_any_q <= 1'b0;
        end else begin
            spike_any_q <= |spike_next;
        end
    end

    assign spike     = spike_q;
    assign spike_any = spike_any_q;

`ifdef SNN_SPIKE_COUNT_EN
    logic [15:0] count_q, count_d;
    logic [3:0]  pop;
    logic [16:0] count_sum;

    always_comb begin
        pop = '0;
        for (int i = 0; i < N_NEURONS; i++) begin
            pop = pop + {3'b000, spike_next[i]};
        end
        count_sum = '0;
        count_d   = count_q;
        if (run) begin
            count_sum = {1'b0, count_q} + {13'b0, pop};
            count_d   = count_sum[16] ? 16'hFFFF : count_sum[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign spike_count = count_q;
`else
    assign spike_count = '0;
`endif

endmodule

// File: tb/tb_snn_osc_network.sv
// -----------------------------------------------------------------------------
// tb_snn_osc_network
// Self-checking bench for snn_osc_network at default parameters. A behavioural
// model advances alongside each driven edge and pushes the expected outputs
// into a scoreboard queue; the queue is popped and compared after the edge.
// -----------------------------------------------------------------------------
module tb_snn_osc_network;

    localparam int N  = 2;
    localparam int VW = 8;
    localparam int AW = 4;
    localparam int TH = 200;
    localparam int RC = 4;

    typedef struct packed {
        logic [N-1:0] spk;
        logic         any;
        logic [15:0]  cnt;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset, run, cfg_valid, cfg_ready;
    logic [AW-1:0] cfg_addr;
    logic [VW-1:0] cfg_wdata;
    logic [N-1:0]  spike;
    logic          spike_any;
    logic [15:0]   spike_count;

    exp_t         sb_q[$];
    int           n_chk  = 0;
    int           n_pass = 0;
    logic [N-1:0] last_spk;
    logic [N-1:0] seen_spk;

    int           mv[N], mr[N], mb[N];
    int           mw[N][N];
    logic [N-1:0] ms;
    int           mcnt;

    snn_osc_network dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .spike       (spike),
        .spike_any   (spike_any),
        .spike_count (spike_count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic model_edge(input logic rst, input logic rn, input logic cv,
                              input logic [AW-1:0] addr, input logic [VW-1:0] wd);
        int           s, syn;
        int           nv[N], nr[N];
        logic [N-1:0] ns;
        logic signed [3:0] w4;
        ns = '0;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                mv[i] = 0; mr[i] = 0; mb[i] = 0;
                for (int j = 0; j < N; j++) mw[i][j] = 0;
            end
            ms   = '0;
            mcnt = 0;
        end else if (rn) begin
            for (int i = 0; i < N; i++) begin
                if (mr[i] != 0) begin
                    nr[i] = mr[i] - 1;
                    nv[i] = 0;
                end else begin
                    syn = 0;
                    for (int j = 0; j < N; j++) if (ms[j]) syn += mw[i][j] * 16;
                    s = mv[i] - mv[i] / 8 + mb[i] + syn;
                    if (s < 0)   s = 0;
                    if (s > 255) s = 255;
                    if (s >= TH) begin
                        ns[i] = 1'b1; nv[i] = 0; nr[i] = RC;
                    end else begin
                        nv[i] = s; nr[i] = 0;
                    end
                end
            end
            for (int i = 0; i < N; i++) begin
                mv[i] = nv[i]; mr[i] = nr[i];
            end
            ms = ns;
`ifdef SNN_SPIKE_COUNT_EN
            mcnt = mcnt + int'(ns[0]) + int'(ns[1]);
            if (mcnt > 65535) mcnt = 65535;
`endif
        end else begin
            if (cv && int'(addr) < N * N) begin
                w4 = wd[3:0];
                mw[int'(addr) / N][int'(addr) % N] = w4;
            end else if (cv && int'(addr) < N * N + N) begin
                mb[int'(addr) - N * N] = int'(wd);
            end
            ms = '0;
        end
    endtask

    task automatic step(input logic rst, input logic rn, input logic cv,
                        input logic [AW-1:0] addr, input logic [VW-1:0] wd);
        exp_t e;
        reset     = rst;
        run       = rn;
        cfg_valid = cv;
        cfg_addr  = addr;
        cfg_wdata = wd;
        #1;
        check_val("cfg_ready", 32'(cfg_ready), 32'(!rn));
        model_edge(rst, rn, cv, addr, wd);
        sb_q.push_back('{spk: ms, any: |ms, cnt: 16'(mcnt)});
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check_val("sb_underflow", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check_val("spike", 32'(spike), 32'(e.spk));
            check_val("spike_any", 32'(spike_any), 32'(e.any));
            check_val("spike_count", 32'(spike_count), 32'(e.cnt));
        end
        last_spk = spike;
        seen_spk = seen_spk | spike;
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic cfg_write(input logic [AW-1:0] addr, input logic [VW-1:0] wd);
        step(1'b0, 1'b0, 1'b1, addr, wd);
    endtask

    task automatic run_n(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b1, 1'b0, '0, '0);
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; cfg_valid = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        seen_spk = '0; last_spk = '0;
        @(posedge clk);
        #1;

        // Reset state
        do_reset();
        check_val("reset_spike", 32'(spike), 32'd0);
        check_val("reset_count", 32'(spike_count), 32'd0);

        // Single neuron oscillation: spike on edges 6 and 16, silent between
        cfg_write(4'd4, 8'd50);
        run_n(5);
        check_val("osc_pre", 32'(last_spk), 32'd0);
        run_n(1);
        check_val("osc_edge6", 32'(last_spk), 32'd1);
        check_val("osc_any6", 32'(spike_any), 32'd1);
        seen_spk = '0;
        run_n(9);
        check_val("osc_gap", 32'(seen_spk), 32'd0);
        run_n(1);
        check_val("osc_edge16", 32'(last_spk), 32'd1);

        // Inhibition: neuron1 fires on edge 4, suppresses neuron0 on edge 6
        do_reset();
        cfg_write(4'd4, 8'd50);
        cfg_write(4'd5, 8'd60);
        cfg_write(4'd1, 8'h08);
        run_n(4);
        check_val("inh_edge4", 32'(last_spk), 32'b10);
        seen_spk = '0;
        run_n(2);
        check_val("inh_edge5_6", 32'(seen_spk), 32'd0);
        run_n(10);

        // Clamp at zero, then raise bias0 so any wrapped potential shows up
        do_reset();
        cfg_write(4'd5, 8'd50);
        cfg_write(4'd1, 8'h08);
        seen_spk = '0;
        run_n(30);
        check_val("clamp_no_spike0", 32'(seen_spk[0]), 32'd0);
        check_val("clamp_spike1", 32'(seen_spk[1]), 32'd1);
        cfg_write(4'd4, 8'd100);
        run_n(12);

        // Config gating: writes during run dropped, out-of-range ignored
        do_reset();
        cfg_write(4'd4, 8'd50);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b1, 4'd4, 8'd200);
        cfg_write(4'd6, 8'hFF);
        cfg_write(4'd15, 8'hFF);
        seen_spk = '0;
        run_n(2);
        check_val("gate_edge5", 32'(seen_spk), 32'd0);
        run_n(1);
        check_val("gate_edge6", 32'(last_spk), 32'd1);
        run_n(10);

        // Reset mid-run with neuron1 refractory and v0 = 133
        do_reset();
        cfg_write(4'd4, 8'd50);
        cfg_write(4'd5, 8'd120);
        run_n(3);
        step(1'b1, 1'b1, 1'b1, 4'd4, 8'd99);
        seen_spk = '0;
        run_n(20);
        check_val("rst_mid_silent", 32'(seen_spk), 32'd0);

        // Spike count over 100 enabled edges, frozen while halted
        do_reset();
        cfg_write(4'd4, 8'd50);
        cfg_write(4'd5, 8'd50);
        run_n(100);
`ifdef SNN_SPIKE_COUNT_EN
        check_val("count_100", 32'(spike_count), 32'd20);
`else
        check_val("count_100", 32'(spike_count), 32'd0);
`endif
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b0, '0, '0);
`ifdef SNN_SPIKE_COUNT_EN
        check_val("count_frozen", 32'(spike_count), 32'd20);
`else
        check_val("count_frozen", 32'(spike_count), 32'd0);
`endif
        check_val("halt_spike", 32'(spike), 32'd0);

        check_val("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
